// File: rtl/sw_sched_pkg.sv
// Shared types and width helpers for the Smith-Waterman job scheduler.
package sw_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RESP
    } state_e;

    localparam int BASE_W = 3;

    function automatic int SEQ_W(input int l);
        return BASE_W * l;
    endfunction

    function automatic int ALIGN_W(input int l);
        return BASE_W * l + 6;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester after ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = ID_W'((int'(ptr_i) + off) % N_REQ);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_id_o    = idx;
            end
        end
    end

endmodule

// File: rtl/sw_job_scheduler.sv
// Single-job controller for the banded Smith-Waterman accelerator: arbitrates
// requesters, sequences acc_start/acc_ready, and returns tagged results.
module sw_job_scheduler
    import sw_sched_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int L         = 8,
    parameter int START_LEN = 2,
    parameter int TIMEOUT   = 255,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*SEQ_W(L)-1:0]     req_r,
    input  logic [N_REQ*SEQ_W(L)-1:0]     req_q,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [ALIGN_W(L)-1:0]         resp_r_aligned,
    output logic [ALIGN_W(L)-1:0]         resp_q_aligned,
    output logic                          resp_timeout,
    output logic                          acc_start,
    output logic [SEQ_W(L)-1:0]           acc_r,
    output logic [SEQ_W(L)-1:0]           acc_q,
    input  logic                          acc_ready,
    input  logic [ALIGN_W(L)-1:0]         acc_r_aligned,
    input  logic [ALIGN_W(L)-1:0]         acc_q_aligned,
    output logic                          busy,
    output logic [15:0]                   job_count
);

    localparam int SW = SEQ_W(L);
    localparam int AW = ALIGN_W(L);
    localparam logic [7:0] LOAD_LAST = 8'(START_LEN - 1);
    localparam logic [7:0] RUN_LAST  = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            seen_low_q, seen_low_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [SW-1:0]   acc_r_q, acc_r_d;
    logic [SW-1:0]   acc_qs_q, acc_qs_d;
    logic [AW-1:0]   resp_r_q, resp_r_d;
    logic [AW-1:0]   resp_qs_q, resp_qs_d;
    logic            resp_to_q, resp_to_d;
    logic [15:0]     job_cnt_q, job_cnt_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic [SW-1:0]    r_arr [N_REQ];
    logic [SW-1:0]    q_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign r_arr[g] = req_r[g*SW +: SW];
        assign q_arr[g] = req_q[g*SW +: SW];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        acc_r_d    = acc_r_q;
        acc_qs_d   = acc_qs_q;
        resp_r_d   = resp_r_q;
        resp_qs_d  = resp_qs_q;
        resp_to_d  = resp_to_q;
        job_cnt_d  = job_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    acc_r_d  = r_arr[gnt_id];
                    acc_qs_d = q_arr[gnt_id];
                    id_d     = gnt_id;
                    ptr_d    = gnt_id;
                    cnt_d    = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    cnt_d      = '0;
                    seen_low_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                // A ready still high from the previous job only counts once it has dropped.
                if (!acc_ready) seen_low_d = 1'b1;
                if (acc_ready && seen_low_q) begin
                    resp_r_d  = acc_r_aligned;
                    resp_qs_d = acc_q_aligned;
                    resp_to_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == RUN_LAST) begin
                    resp_r_d  = '0;
                    resp_qs_d = '0;
                    resp_to_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    job_cnt_d = job_cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
            ptr_q      <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            acc_r_q    <= '0;
            acc_qs_q   <= '0;
            resp_r_q   <= '0;
            resp_qs_q  <= '0;
            resp_to_q  <= 1'b0;
            job_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            acc_r_q    <= acc_r_d;
            acc_qs_q   <= acc_qs_d;
            resp_r_q   <= resp_r_d;
            resp_qs_q  <= resp_qs_d;
            resp_to_q  <= resp_to_d;
            job_cnt_q  <= job_cnt_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE) ? gnt : '0;
    assign acc_start      = (state_q != ST_RUN);
    assign acc_r          = acc_r_q;
    assign acc_q          = acc_qs_q;
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_id        = id_q;
    assign resp_r_aligned = resp_r_q;
    assign resp_q_aligned = resp_qs_q;
    assign resp_timeout   = resp_to_q;
    assign busy           = (state_q != ST_IDLE);
    assign job_count      = job_cnt_q;

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Scoreboard bench for sw_job_scheduler with a behavioural accelerator model.
module tb_sw_job_scheduler;

    localparam int N  = 2;
    localparam int L  = 8;
    localparam int SL = 2;
    localparam int TO = 255;
    localparam int SW = 3 * L;
    localparam int AW = 3 * L + 6;
    localparam int IW = $clog2(N);

    logic            clk, reset_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*SW-1:0] req_r, req_q;
    logic            resp_valid, resp_ready, resp_timeout;
    logic [IW-1:0]   resp_id;
    logic [AW-1:0]   resp_r_aligned, resp_q_aligned;
    logic            acc_start, acc_ready, busy;
    logic [SW-1:0]   acc_r, acc_q;
    logic [AW-1:0]   acc_r_aligned, acc_q_aligned;
    logic [15:0]     job_count;

    sw_job_scheduler #(.N_REQ(N), .L(L), .START_LEN(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_r(req_r), .req_q(req_q),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_r_aligned(resp_r_aligned), .resp_q_aligned(resp_q_aligned),
        .resp_timeout(resp_timeout),
        .acc_start(acc_start), .acc_r(acc_r), .acc_q(acc_q), .acc_ready(acc_ready),
        .acc_r_aligned(acc_r_aligned), .acc_q_aligned(acc_q_aligned),
        .busy(busy), .job_count(job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] r;
        logic [AW-1:0] q;
        logic          to;
    } exp_t;

    int          vectors = 0;
    int          errors  = 0;
    exp_t        sb[$];
    int          exp_jobs;
    int          hold_cnt;
    bit          mon_en, job_go, aborted;
    int          cur_s, cur_done;
    logic [AW-1:0] cur_ar, cur_aq;
    logic [SW-1:0] job_r, job_q;
    bit          pend_v [N];
    logic [SW-1:0] pend_r [N];
    logic [SW-1:0] pend_q [N];
    int          mptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_reqs();
        logic [N*SW-1:0] tr, tq;
        tr = '0;
        tq = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend_v[i];
            tr = tr | ((N*SW)'(pend_r[i]) << (i * SW));
            tq = tq | ((N*SW)'(pend_q[i]) << (i * SW));
        end
        req_r = tr;
        req_q = tq;
    endtask

    task automatic new_job(input int i);
        pend_v[i] = 1'b1;
        pend_r[i] = SW'($urandom);
        pend_q[i] = SW'($urandom);
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        drive_reqs();
    endtask

    // Round-robin rule: first pending requester after the last one served.
    function automatic int model_grant();
        for (int off = 1; off <= N; off++) begin
            if (pend_v[(mptr + off) % N]) return (mptr + off) % N;
        end
        return 0;
    endfunction

    // Called at a negedge with the DUT idle and at least one job pending.
    task automatic issue(input int s, input int done, input bit refill, input int hold,
                         input bit wait_done, input logic [AW-1:0] ar, input logic [AW-1:0] aq);
        int g;
        bit ok;
        exp_t e;
        logic [N-1:0] oh;
        drive_reqs();
        g        = model_grant();
        oh       = N'(1) << g;
        cur_s    = s;
        cur_done = done;
        cur_ar   = ar;
        cur_aq   = aq;
        hold_cnt = hold;
        aborted  = 1'b0;
        #1;
        check("req_ready_grant", 64'(req_ready), 64'(oh));
        @(posedge clk);
        e.id = IW'(g);
        e.to = (done == 0);
        e.r  = (done == 0) ? '0 : ar;
        e.q  = (done == 0) ? '0 : aq;
        sb.push_back(e);
        mptr  = g;
        job_r = pend_r[g];
        job_q = pend_q[g];
        if (refill) new_job(g);
        else pend_v[g] = 1'b0;
        job_go = 1'b1;
        @(negedge clk);
        drive_reqs();
        if (wait_done) begin
            ok = 1'b0;
            for (int c = 0; c < 600; c++) begin
                if (sb.size() == 0) begin
                    ok = 1'b1;
                    break;
                end
                check("req_ready_busy", 64'(req_ready), 64'(0));
                @(negedge clk);
            end
            if (!ok) begin
                vectors++;
                errors++;
                $display("FAIL job_done: no response within 600 cycles, want one");
            end
            @(negedge clk);
        end
    endtask

    // Accelerator model: stale ready for the first cur_s RUN cycles, then low,
    // then high from RUN cycle cur_done (never when cur_done is 0).
    initial begin : acc_model
        int lc;
        int k;
        acc_ready     = 1'b0;
        acc_r_aligned = '0;
        acc_q_aligned = '0;
        job_go        = 1'b0;
        forever begin
            wait (job_go == 1'b1);
            job_go        = 1'b0;
            acc_ready     = (cur_s > 0);
            acc_r_aligned = ~cur_ar;
            acc_q_aligned = ~cur_aq;
            lc = 0;
            @(negedge clk);
            while (acc_start && lc < SL + 8) begin
                lc++;
                @(negedge clk);
            end
            if (!aborted) begin
                check("load_cycles", 64'(lc), 64'(SL));
                check("acc_r_latched", 64'(acc_r), 64'(job_r));
                check("acc_q_latched", 64'(acc_q), 64'(job_q));
            end
            k = 0;
            while (!acc_start && !resp_valid && k < TO + 20) begin
                k++;
                acc_ready = (k <= cur_s) || (cur_done != 0 && k >= cur_done);
                if (cur_done != 0 && k >= cur_done) begin
                    acc_r_aligned = cur_ar;
                    acc_q_aligned = cur_aq;
                end else begin
                    acc_r_aligned = ~cur_ar;
                    acc_q_aligned = ~cur_aq;
                end
                @(negedge clk);
            end
            if (!aborted) begin
                check("run_cycles", 64'(k), 64'((cur_done != 0) ? cur_done : TO));
                check("acc_r_stable", 64'(acc_r), 64'(job_r));
            end
        end
    end

    initial begin : monitor
        exp_t h;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("job_count", 64'(job_count), 64'(16'(exp_jobs)));
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL spurious_resp: resp_valid=1 id=%0d, want no response", resp_id);
                    end else begin
                        h = sb[0];
                        check("resp_id", 64'(resp_id), 64'(h.id));
                        check("resp_r_aligned", 64'(resp_r_aligned), 64'(h.r));
                        check("resp_q_aligned", 64'(resp_q_aligned), 64'(h.q));
                        check("resp_timeout", 64'(resp_timeout), 64'(h.to));
                    end
                    if (hold_cnt > 0) begin
                        resp_ready = 1'b0;
                        hold_cnt--;
                    end else begin
                        resp_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (resp_ready) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        exp_jobs++;
                    end
                end else begin
                    resp_ready = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int s;
        reset_n   = 1'b0;
        req_valid = '0;
        req_r     = '0;
        req_q     = '0;
        mon_en    = 1'b0;
        exp_jobs  = 0;
        hold_cnt  = 0;
        aborted   = 1'b0;
        mptr      = N - 1;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_r[i] = '0;
            pend_q[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acc_start", 64'(acc_start), 64'(1));
        check("rst_acc_r", 64'(acc_r), 64'(0));
        check("rst_acc_q", 64'(acc_q), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_id", 64'(resp_id), 64'(0));
        check("rst_resp_r", 64'(resp_r_aligned), 64'(0));
        check("rst_resp_q", 64'(resp_q_aligned), 64'(0));
        check("rst_resp_timeout", 64'(resp_timeout), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_job_count", 64'(job_count), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Both requesters continuously valid: grants alternate.
        new_job(0);
        new_job(1);
        for (int j = 0; j < 4; j++) begin
            s = $urandom_range(0, 2);
            issue(s, s + 2 + $urandom_range(0, 10), 1'b1, 0, 1'b1, AW'($urandom), AW'($urandom));
        end
        clear_pend();

        // Single directed job from requester 0.
        pend_v[0] = 1'b1;
        pend_r[0] = 24'h1A2B3C;
        pend_q[0] = 24'h1A2B3C;
        issue(0, 40, 1'b0, 0, 1'b1, 30'h0ABCDEF, 30'h0FEDCB);

        // Stale ready through LOAD and 3 RUN cycles; completion only at cycle 20.
        new_job(1);
        issue(3, 20, 1'b0, 0, 1'b1, AW'($urandom), AW'($urandom));

        // Accelerator never answers: timeout response.
        new_job(0);
        issue(0, 0, 1'b0, 0, 1'b1, AW'($urandom), AW'($urandom));

        // Consumer stalls 10 cycles while both requesters keep asking.
        new_job(0);
        new_job(1);
        issue(1, 15, 1'b1, 10, 1'b1, AW'($urandom), AW'($urandom));
        clear_pend();

        // Reset pulsed in the middle of RUN.
        new_job(1);
        issue(0, 200, 1'b0, 0, 1'b0, AW'($urandom), AW'($urandom));
        repeat (SL + 5) @(negedge clk);
        aborted = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        exp_jobs = 0;
        mptr     = N - 1;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_acc_start", 64'(acc_start), 64'(1));
        check("midrst_resp_valid", 64'(resp_valid), 64'(0));
        check("midrst_job_count", 64'(job_count), 64'(0));
        @(negedge clk);

        // Randomised traffic.
        for (int j = 0; j < 14; j++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1) new_job(i);
                any = any | pend_v[i];
            end
            if (!any) new_job($urandom_range(0, N - 1));
            s = $urandom_range(0, 4);
            issue(s, s + 2 + $urandom_range(0, 25), 1'b0, $urandom_range(0, 3), 1'b1,
                  AW'($urandom), AW'($urandom));
        end
        clear_pend();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
